// File: rtl/dataout_window_acc.sv
// Windowed statistics over the upstream DATAOUT stream: collects WIN valid
// samples, then publishes sum, average, max and min with a one-cycle pulse.
module dataout_window_acc #(
  parameter int DATA_W  = 6,
  parameter int WIN     = 8,
  parameter int LOG_WIN = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      din_valid,
  input  logic [DATA_W-1:0]         din,
  output logic                      busy,
  output logic                      result_valid,
  output logic [DATA_W+LOG_WIN-1:0] sum,
  output logic [DATA_W-1:0]         avg,
  output logic [DATA_W-1:0]         max_s,
  output logic [DATA_W-1:0]         min_s
);

  localparam int ACC_W = DATA_W + LOG_WIN;
  localparam logic [LOG_WIN-1:0] LAST = LOG_WIN'(WIN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state;
  logic [LOG_WIN-1:0]  count;
  logic [ACC_W-1:0]    acc;
  logic [DATA_W-1:0]   cur_max;
  logic [DATA_W-1:0]   cur_min;

  logic [ACC_W-1:0]    acc_next;
  logic [DATA_W-1:0]   max_next;
  logic [DATA_W-1:0]   min_next;

  // Running values including the sample on din; the first sample of a
  // window seeds both extremes so the cleared registers never win a compare.
  always_comb begin
    acc_next = acc + ACC_W'(din);
    max_next = cur_max;
    min_next = cur_min;
    if (count == '0) begin
      max_next = din;
      min_next = din;
    end else begin
      if (din > cur_max) max_next = din;
      if (din < cur_min) min_next = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      acc          <= '0;
      cur_max      <= '0;
      cur_min      <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      sum          <= '0;
      avg          <= '0;
      max_s        <= '0;
      min_s        <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state   <= ACCUM;
            busy    <= 1'b1;
            count   <= '0;
            acc     <= '0;
            cur_max <= '0;
            cur_min <= '0;
          end
        end
        ACCUM: begin
          if (din_valid) begin
            acc     <= acc_next;
            count   <= count + LOG_WIN'(1);
            cur_max <= max_next;
            cur_min <= min_next;
            // Publish on the same edge that accepts the last sample.
            if (count == LAST) begin
              state        <= DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
              sum          <= acc_next;
              avg          <= DATA_W'(acc_next >> LOG_WIN);
              max_s        <= max_next;
              min_s        <= min_next;
            end
          end
        end
        DONE: begin
          if (start) begin
            state   <= ACCUM;
            busy    <= 1'b1;
            count   <= '0;
            acc     <= '0;
            cur_max <= '0;
            cur_min <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dataout_window_acc.sv
// Scoreboard bench for dataout_window_acc: a bench-side model pushes each
// window's expected statistics; a monitor pops and compares on result_valid.
module tb_dataout_window_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       din_valid;
  logic [5:0] din;
  logic       busy;
  logic       result_valid;
  logic [8:0] sum;
  logic [5:0] avg;
  logic [5:0] max_s;
  logic [5:0] min_s;

  typedef struct {
    int sum;
    int avg;
    int mx;
    int mn;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   windows_pushed = 0;
  int   windows_seen = 0;
  int   model_n = 0;
  int   model_acc = 0;
  int   model_max = 0;
  int   model_min = 0;
  logic prev_rv = 1'b0;

  dataout_window_acc #(.DATA_W(6), .WIN(8), .LOG_WIN(3)) dut (
    .clk(clk), .rst(rst), .start(start), .din_valid(din_valid), .din(din),
    .busy(busy), .result_valid(result_valid), .sum(sum), .avg(avg),
    .max_s(max_s), .min_s(min_s)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference model: called only for samples the DUT should accept.
  function automatic void modelSample(input int d);
    if (model_n == 0) begin
      model_max = d;
      model_min = d;
    end else begin
      if (d > model_max) model_max = d;
      if (d < model_min) model_min = d;
    end
    model_acc += d;
    model_n++;
    if (model_n == 8) begin
      exp_q.push_back('{sum: model_acc, avg: model_acc / 8, mx: model_max, mn: model_min});
      windows_pushed++;
      model_n = 0;
      model_acc = 0;
    end
  endfunction

  task automatic applyStimulus(input logic s, input logic v, input logic [5:0] d, input bit counted);
    @(posedge clk);
    #1;
    start     = s;
    din_valid = v;
    din       = d;
    if (counted && v) modelSample(int'(d));
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && result_valid) begin
      windows_seen++;
      checkOutput("rv_single_cycle", int'(prev_rv), 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sum", int'(sum), e.sum);
        checkOutput("avg", int'(avg), e.avg);
        checkOutput("max_s", int'(max_s), e.mx);
        checkOutput("min_s", int'(min_s), e.mn);
      end
    end
    prev_rv <= rst ? 1'b0 : result_valid;
  end

  initial begin
    rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
    #12;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_rv", int'(result_valid), 0);
    checkOutput("rst_sum", int'(sum), 0);
    checkOutput("rst_avg", int'(avg), 0);
    checkOutput("rst_max", int'(max_s), 0);
    checkOutput("rst_min", int'(min_s), 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: start with a same-cycle sample in IDLE (not counted), then 8 x 5.
    applyStimulus(1'b1, 1'b1, 6'd60, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 6'd5, 1'b1);
    idleCycle();
    checkOutput("t1_rv_latency", int'(result_valid), 1);
    checkOutput("t1_busy_done", int'(busy), 0);
    idleCycle();
    checkOutput("t1_rv_cleared", int'(result_valid), 0);
    checkOutput("t1_sum_hold", int'(sum), 40);

    // Test 2: full-scale samples.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 6'd63, 1'b1);
    idleCycle();
    idleCycle();

    // Test 3: ramp with gaps of varying length.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 6'(i), 1'b1);
      for (int g = 0; g <= i % 3; g++) applyStimulus(1'b0, 1'b0, 6'd33, 1'b0);
    end
    idleCycle();
    idleCycle();

    // Test 4: reset mid-window discards the partial window.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 6'd9, 1'b0);
    idleCycle();
    checkOutput("t4_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    #2;
    checkOutput("t4_busy", int'(busy), 0);
    checkOutput("t4_rv", int'(result_valid), 0);
    checkOutput("t4_sum", int'(sum), 0);
    checkOutput("t4_avg", int'(avg), 0);
    checkOutput("t4_max", int'(max_s), 0);
    checkOutput("t4_min", int'(min_s), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 6'd2, 1'b1);
    idleCycle();
    idleCycle();

    // Test 5: start mid-window ignored; start in DONE restarts at once.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 6'd3, 1'b1);
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 6'd3, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 6'd3, 1'b1);
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    checkOutput("t5_rv", int'(result_valid), 1);
    idleCycle();
    checkOutput("t5_busy_restart", int'(busy), 1);
    checkOutput("t5_sum_held", int'(sum), 24);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 6'd1, 1'b1);
    idleCycle();
    checkOutput("t5_sum_second", int'(sum), 8);
    idleCycle();

    // Test 6: 100 back-to-back random windows with start held high.
    applyStimulus(1'b1, 1'b1, 6'($urandom_range(0, 63)), 1'b0);
    for (int w = 0; w < 100; w++) begin
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 6'($urandom_range(0, 63)), 1'b1);
      applyStimulus(w < 99, 1'b1, 6'($urandom_range(0, 63)), 1'b0);
      checkOutput("t6_busy_in_done", int'(busy), 0);
    end
    idleCycle();
    idleCycle();
    checkOutput("t6_idle_busy", int'(busy), 0);

    checkOutput("queue_empty", exp_q.size(), 0);
    checkOutput("windows_seen", windows_seen, windows_pushed);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
